// File: rtl/bus_arbiter_wrr_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_wrr_if
//  Description : Request/grant and configuration signals shared between the
//                bus masters and the weighted round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_wrr_if #(
    parameter int NUM_MASTERS = 4,
    parameter int CFG_ADDR_W  = 4
);
    localparam int c_ID_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] lock;
    logic [NUM_MASTERS-1:0] grant;
    logic                   grant_valid;
    logic [c_ID_W-1:0]      grant_id;
    logic                   config_wr;
    logic [CFG_ADDR_W-1:0]  config_addr;
    logic [7:0]             config_data;
    logic [7:0]             config_rdata;

    // Requester / configuration agent side
    modport master (
        output req, lock, config_wr, config_addr, config_data,
        input  grant, grant_valid, grant_id, config_rdata
    );

    // Arbiter side
    modport slave (
        input  req, lock, config_wr, config_addr, config_data,
        output grant, grant_valid, grant_id, config_rdata
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_wrr.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_wrr
//  Description : N-master bus arbiter with round-robin, weighted round-robin
//                and fixed-priority modes, per-master enable mask and bus
//                lock. Registered one-hot grant, register-mapped config.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_wrr #(
    parameter int NUM_MASTERS = 4,
    parameter int WEIGHT_W    = 4,
    parameter int CFG_ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    bus_arbiter_wrr_if.slave  bus
);
    localparam int c_ID_W = $clog2(NUM_MASTERS);

    // Configuration registers
    logic [1:0]             r_ctrl;
    logic [NUM_MASTERS-1:0] r_enable;
    logic [WEIGHT_W-1:0]    r_weight [NUM_MASTERS];

    // Arbitration state
    logic [NUM_MASTERS-1:0] r_grant;
    logic                   r_grant_valid;
    logic [c_ID_W-1:0]      r_grant_id;
    logic [c_ID_W-1:0]      r_rr_ptr;
    logic [WEIGHT_W-1:0]    r_credit;

    // Next-state and helper wires
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic                   w_valid_nxt;
    logic [c_ID_W-1:0]      w_id_nxt;
    logic [c_ID_W-1:0]      w_rr_ptr_nxt;
    logic [WEIGHT_W-1:0]    w_credit_nxt;
    logic [NUM_MASTERS-1:0] w_elig;
    logic                   w_fixed;
    logic                   w_weighted;
    logic                   w_rr_found;
    logic [c_ID_W-1:0]      w_rr_win;
    logic [c_ID_W-1:0]      w_fp_win;
    logic [c_ID_W-1:0]      w_scan_idx;
    logic [c_ID_W-1:0]      w_win;
    logic                   w_keep;
    logic [7:0]             w_rdata;
    logic                   w_unused_data;

    assign w_fixed    = r_ctrl[0];
    assign w_weighted = r_ctrl[1];
    assign w_elig     = bus.req & r_enable;
    assign w_win      = w_fixed ? w_fp_win : w_rr_win;

    // Owner keeps the bus while still eligible and either locked or, in the
    // round-robin modes, still holding more than one credit.
    assign w_keep = r_grant_valid && w_elig[r_grant_id] &&
                    (bus.lock[r_grant_id] || (!w_fixed && (r_credit > WEIGHT_W'(1))));

    // Round-robin search: first eligible index at or after the pointer, wrapping
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        w_scan_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_scan_idx = c_ID_W'((int'(r_rr_ptr) + i) % NUM_MASTERS);
            if (!w_rr_found && w_elig[w_scan_idx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_scan_idx;
            end
        end
    end

    // Fixed priority search: scanning downward leaves the lowest eligible index
    always_comb begin
        w_fp_win = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_fp_win = c_ID_W'(i);
            end
        end
    end

    // Next grant, pointer and credit decision
    always_comb begin
        w_grant_nxt  = '0;
        w_valid_nxt  = 1'b0;
        w_id_nxt     = '0;
        w_rr_ptr_nxt = r_rr_ptr;
        w_credit_nxt = r_credit;
        if (w_keep) begin
            w_grant_nxt = r_grant;
            w_valid_nxt = 1'b1;
            w_id_nxt    = r_grant_id;
            // Credit floors at zero so a long locked burst cannot wrap it
            if (!w_fixed && (r_credit != '0)) begin
                w_credit_nxt = r_credit - WEIGHT_W'(1);
            end
        end else if (|w_elig) begin
            w_grant_nxt[w_win] = 1'b1;
            w_valid_nxt        = 1'b1;
            w_id_nxt           = w_win;
            if (!w_fixed) begin
                w_rr_ptr_nxt = (w_win == c_ID_W'(NUM_MASTERS - 1)) ? '0 : w_win + c_ID_W'(1);
                if (w_weighted && (r_weight[w_win] != '0)) begin
                    w_credit_nxt = r_weight[w_win];
                end else begin
                    w_credit_nxt = WEIGHT_W'(1);
                end
            end
        end
    end

    // Arbitration state registers; reset drops the grant asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_credit      <= '0;
        end else begin
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_valid_nxt;
            r_grant_id    <= w_id_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_credit      <= w_credit_nxt;
        end
    end

    // Configuration register writes; unmapped addresses are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl   <= '0;
            r_enable <= '1;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                r_weight[i] <= WEIGHT_W'(1);
            end
        end else if (bus.config_wr) begin
            if (bus.config_addr == CFG_ADDR_W'(0)) begin
                r_ctrl <= bus.config_data[1:0];
            end
            if (bus.config_addr == CFG_ADDR_W'(1)) begin
                r_enable <= bus.config_data[NUM_MASTERS-1:0];
            end
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (bus.config_addr == CFG_ADDR_W'(2 + i)) begin
                    r_weight[i] <= bus.config_data[WEIGHT_W-1:0];
                end
            end
        end
    end

    // Combinational readback, zero-extended; unmapped addresses read zero
    always_comb begin
        w_rdata = '0;
        if (bus.config_addr == CFG_ADDR_W'(0)) begin
            w_rdata = 8'(r_ctrl);
        end
        if (bus.config_addr == CFG_ADDR_W'(1)) begin
            w_rdata = 8'(r_enable);
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (bus.config_addr == CFG_ADDR_W'(2 + i)) begin
                w_rdata = 8'(r_weight[i]);
            end
        end
    end

    // Data bits beyond the mapped fields carry no meaning
    assign w_unused_data = ^bus.config_data;

    assign bus.grant        = r_grant;
    assign bus.grant_valid  = r_grant_valid;
    assign bus.grant_id     = r_grant_id;
    assign bus.config_rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_wrr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter_wrr
//  Description : Self-checking bench for bus_arbiter_wrr (4 masters, 4-bit
//                weights) with an expected-grant scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_wrr;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    logic [3:0] sb_q[$];

    bus_arbiter_wrr_if #(.NUM_MASTERS(4), .CFG_ADDR_W(4)) bus ();

    bus_arbiter_wrr #(
        .NUM_MASTERS (4),
        .WEIGHT_W    (4),
        .CFG_ADDR_W  (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2id(input logic [3:0] g);
        int id;
        id = 0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) id = i;
        end
        return id;
    endfunction

    // Pop one expectation per clock and compare the registered outputs
    task automatic drain(input string tag);
        logic [3:0] e;
        while (sb_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            chk({tag, "_grant"},       32'(bus.grant),       32'(e));
            chk({tag, "_grant_valid"}, 32'(bus.grant_valid), 32'(|e));
            chk({tag, "_grant_id"},    32'(bus.grant_id),    32'(oh2id(e)));
        end
    endtask

    task automatic push_n(input logic [3:0] g, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(g);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        bus.config_addr = a;
        bus.config_data = d;
        bus.config_wr   = 1'b1;
        @(posedge clk);
        #1;
        bus.config_wr   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus.config_addr = a;
        #1;
        chk(tag, 32'(bus.config_rdata), 32'(exp));
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        bus.req  = '0;
        bus.lock = '0;
        bus.config_wr = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        bus.config_wr   = 1'b0;
        bus.config_addr = '0;
        bus.config_data = '0;
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        // Reset state
        chk("rst_grant",       32'(bus.grant),       32'h0);
        chk("rst_grant_valid", 32'(bus.grant_valid), 32'h0);
        chk("rst_grant_id",    32'(bus.grant_id),    32'h0);
        rd_chk("rst_ctrl",   4'd0, 8'h00);
        rd_chk("rst_enable", 4'd1, 8'h0F);
        rd_chk("rst_weight", 4'd2, 8'h01);
        reset_n = 1'b1;

        // 1. Grant one cycle after request, async drop, restart from pointer 0
        bus.req = 4'b0001;
        push_n(4'b0001, 1);
        drain("t1a");
        #2 reset_n = 1'b0;
        #1;
        chk("t1_async_grant",       32'(bus.grant),       32'h0);
        chk("t1_async_grant_valid", 32'(bus.grant_valid), 32'h0);
        bus.req = 4'b1111;
        #1 reset_n = 1'b1;
        push_n(4'b0001, 1); push_n(4'b0010, 1); push_n(4'b0100, 1); push_n(4'b1000, 1);
        drain("t1b");

        // 2. Plain round-robin
        do_reset();
        bus.req = 4'b1010;
        push_n(4'b0010, 1); push_n(4'b1000, 1); push_n(4'b0010, 1); push_n(4'b1000, 1);
        drain("t2");

        // 3. Weighted round-robin
        do_reset();
        cfg_write(4'd0, 8'h02);
        cfg_write(4'd3, 8'h03);
        cfg_write(4'd5, 8'h01);
        rd_chk("t3_rd_weight1", 4'd3, 8'h03);
        bus.req = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            push_n(4'b0010, 3);
            push_n(4'b1000, 1);
        end
        drain("t3");

        // 4. Fixed priority, preemptive
        bus.req = 4'b0000;
        cfg_write(4'd0, 8'h01);
        bus.req = 4'b1111;
        push_n(4'b0001, 3);
        drain("t4a");
        bus.req = 4'b1110;
        push_n(4'b0010, 1);
        drain("t4b");
        bus.req = 4'b1111;
        push_n(4'b0001, 1);
        drain("t4c");

        // 5. Enable mask; the write edge still arbitrates on the old mask
        bus.req = 4'b0010;
        cfg_write(4'd1, 8'h0D);
        chk("t5_oldcfg_grant", 32'(bus.grant), 32'h2);
        push_n(4'b0000, 2);
        drain("t5");
        rd_chk("t5_rd_enable",   4'd1,  8'h0D);
        rd_chk("t5_rd_unmapped", 4'd15, 8'h00);

        // 6. Lock holds, lock drop hands over, req drop beats lock
        do_reset();
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        push_n(4'b0100, 1);
        drain("t6a");
        bus.req = 4'b0101;
        push_n(4'b0100, 5);
        drain("t6b");
        bus.lock = 4'b0000;
        push_n(4'b0001, 1);
        drain("t6c");
        bus.lock = 4'b0001;
        push_n(4'b0001, 2);
        drain("t6d");
        bus.req = 4'b0100;
        push_n(4'b0100, 1);
        drain("t6e");
        bus.req = 4'b0000;
        push_n(4'b0000, 1);
        drain("t6f");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
